ser_arbiter: RTL and testbench
==============================

SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (legal values 2, 4 or 8).
REQ-002 The block SHALL have parameter DATA_W, default 4, giving the width of each parallel word in bits (legal values 2 to 16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_i, input, NREQ bits: per-requester request, level-held.
REQ-006 The block SHALL have port data_i, input, NREQ*DATA_W bits: requester k word at data_i[k*DATA_W +: DATA_W].
REQ-007 The block SHALL have port ack_o, output, NREQ bits: one-hot grant pulse, one cycle wide.
REQ-008 The block SHALL have port serial_o, output, 1 bit: serial data, LSB first.
REQ-009 The block SHALL have port valid_o, output, 1 bit: serial_o carries a data bit.
REQ-010 The block SHALL have port first_o, output, 1 bit: high with bit 0 of each word.
REQ-011 The block SHALL have port src_o, output, clog2(NREQ) bits: index of the requester whose word is being shifted.
REQ-012 The block SHALL have port empty_o, output, 1 bit: high when the block is in IDLE (no word held).

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and SHIFT, plus an internal DATA_W-bit shift register, a bit counter and a round-robin pointer last_ff.
REQ-014 In IDLE with req_i == 0, the block SHALL hold all outputs at their reset values.
REQ-015 In IDLE with req_i != 0 at a rising edge (the grant edge), the block SHALL take the following actions:
- select winner w as the first asserted requester searching last_ff+1, last_ff+2, ... modulo NREQ;
- load data_i word w into the shift register;
- set src_o = w and last_ff = w;
- pulse ack_o[w] for exactly the cycle following the edge;
- enter SHIFT with the counter at 0.
REQ-016 In SHIFT, the block SHALL perform the following on each rising edge:
- drive serial_o = shift register bit 0 and valid_o = 1;
- set first_o = 1 only when counter == 0;
- shift the register right with zero fill;
- increment the counter.
REQ-017 On the edge at which counter == DATA_W-1, the block SHALL emit the last bit and return to IDLE.
REQ-018 Each word SHALL therefore produce exactly DATA_W consecutive valid_o cycles, starting two cycles after the grant edge.
REQ-019 On the first edge in IDLE after a word, the block SHALL drive valid_o = 0, serial_o = 0 and first_o = 0. This guarantees at least one invalid cycle between words, and that edge may itself be a grant edge.
REQ-020 empty_o SHALL be 0 from the grant edge through the last-bit edge and 1 otherwise; src_o SHALL hold its value until the next grant.
REQ-021 The block SHALL ignore req_i and data_i while in SHIFT and SHALL sample data only at the grant edge.
REQ-022 A requester deasserting req_i before its ack SHALL simply not be granted, with no error.
REQ-023 A requester holding req_i after its ack SHALL be treated as a new request at the next arbitration.
REQ-024 With all requesters continuously requesting, grants SHALL rotate strictly 0,1,2,...,NREQ-1,0,...
REQ-025 At most one ack_o bit SHALL be high in any cycle, and ack_o SHALL never be high while valid_o is high for a previous word.

Reset
REQ-026 While reset is high, the block SHALL asynchronously force the following values:
- state = IDLE;
- ack_o = 0, serial_o = 0, valid_o = 0, first_o = 0;
- src_o = 0, empty_o = 1;
- shift register = 0, counter = 0;
- last_ff = NREQ-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-word SHALL discard remaining bits with no further valid_o. After release, the block SHALL arbitrate afresh from requester 0 at the first rising edge with reset low.

Verification
REQ-028 Single request: req_i=4'b0100, word 2 = 4'b1011 -> ack_o=4'b0100 one cycle; serial_o 1,1,0,1 with valid_o high 4 cycles; first_o on the first bit; src_o=2; empty_o=1 after.
REQ-029 Contention: req_i=4'b1111 held continuously, words 4'h1,4'h2,4'h4,4'h8 -> grants 0,1,2,3,0 in order; each word serialized correctly; exactly one valid_o=0 cycle between words.
REQ-030 Fairness: req_i=4'b1001 held after a grant to 3 -> next grant 0, then 3, alternating.
REQ-031 Late data change: data_i word changed during SHIFT -> serialized bits equal the value sampled at the grant edge.
REQ-032 Reset mid-operation: reset pulsed after bit 1 of 4'b1111 -> valid_o=0 immediately; no remaining bits; next grant with req_i=4'b1110 goes to 1.
REQ-033 Withdrawn request: req_i[1] pulsed high then low while in SHIFT -> no ack_o[1] and no word from requester 1.

Source files
------------

// File: rtl/ser_arbiter.sv
// Round-robin arbiter that grants one requester at a time and shifts its
// parallel word out LSB first on a single serial line.
module ser_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*DATA_W-1:0]   data_i,
    output logic [NREQ-1:0]          ack_o,
    output logic                     serial_o,
    output logic                     valid_o,
    output logic                     first_o,
    output logic [$clog2(NREQ)-1:0]  src_o,
    output logic                     empty_o
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [SW-1:0]     last_ff;
    logic [SW-1:0]     last_nxt;
    logic [SW-1:0]     src_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic              serial_nxt;
    logic              valid_nxt;
    logic              first_nxt;
    logic [SW-1:0]     win;
    logic              any_req;

    // NREQ is a power of two, so the natural wrap of the adder gives the
    // modulo search order last+1, last+2, ...; scanning from the far end
    // lets the nearest asserted requester overwrite the others.
    function automatic logic [SW-1:0] pick_winner(input logic [NREQ-1:0] req,
                                                  input logic [SW-1:0]   last);
        logic [SW-1:0] cand;
        pick_winner = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = last + SW'(i);
            if (req[cand]) begin
                pick_winner = cand;
            end
        end
    endfunction

    assign win     = pick_winner(req_i, last_ff);
    assign any_req = |req_i;
    assign empty_o = (state == IDLE);

    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        cnt_nxt    = cnt;
        last_nxt   = last_ff;
        src_nxt    = src_o;
        ack_nxt    = '0;
        serial_nxt = 1'b0;
        valid_nxt  = 1'b0;
        first_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    sreg_nxt  = data_i[int'(win)*DATA_W +: DATA_W];
                    src_nxt   = win;
                    last_nxt  = win;
                    ack_nxt   = NREQ'(1) << win;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                serial_nxt = sreg[0];
                valid_nxt  = 1'b1;
                first_nxt  = (cnt == '0);
                sreg_nxt   = {1'b0, sreg[DATA_W-1:1]};
                cnt_nxt    = cnt + CW'(1);
                if (cnt == CW'(DATA_W-1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset leaves the pointer on the last requester so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            last_ff  <= SW'(NREQ-1);
            src_o    <= '0;
            ack_o    <= '0;
            serial_o <= 1'b0;
            valid_o  <= 1'b0;
            first_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            cnt      <= cnt_nxt;
            last_ff  <= last_nxt;
            src_o    <= src_nxt;
            ack_o    <= ack_nxt;
            serial_o <= serial_nxt;
            valid_o  <= valid_nxt;
            first_o  <= first_nxt;
        end
    end

endmodule

// File: tb/tb_ser_arbiter.sv
// Directed bench for ser_arbiter: single grant, contention, fairness,
// late data change, withdrawn request and reset mid-word.
module tb_ser_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_i;
    logic [NREQ*DATA_W-1:0] data_i;
    logic [NREQ-1:0]        ack_o;
    logic                   serial_o;
    logic                   valid_o;
    logic                   first_o;
    logic [1:0]             src_o;
    logic                   empty_o;

    int compare_count  = 0;
    int mismatch_count = 0;

    ser_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .serial_o (serial_o),
        .valid_o  (valid_o),
        .first_o  (first_o),
        .src_o    (src_o),
        .empty_o  (empty_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        if (obs !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ*DATA_W-1:0] data);
        req_i  = req;
        data_i = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".valid"},  valid_o,  0);
        checkOutput({tag, ".serial"}, serial_o, 0);
        checkOutput({tag, ".first"},  first_o,  0);
        checkOutput({tag, ".ack"},    ack_o,    0);
        checkOutput({tag, ".empty"},  empty_o,  1);
    endtask

    // Grant edge, then DATA_W shift edges; inputs switch to the *_during
    // values right after the grant so late changes must be ignored.
    task automatic runWord(input int w, input logic [DATA_W-1:0] word,
                           input logic [NREQ-1:0] req_during,
                           input logic [NREQ*DATA_W-1:0] data_during);
        logic [NREQ-1:0] exp_ack;
        exp_ack = 4'b0001 << w;
        tick();
        checkOutput("grant.ack",   ack_o,    exp_ack);
        checkOutput("grant.src",   src_o,    w);
        checkOutput("grant.empty", empty_o,  0);
        checkOutput("grant.valid", valid_o,  0);
        checkOutput("grant.ser",   serial_o, 0);
        applyStimulus(req_during, data_during);
        for (int b = 0; b < DATA_W; b++) begin
            tick();
            checkOutput("bit.valid", valid_o,  1);
            checkOutput("bit.ser",   serial_o, word[b]);
            checkOutput("bit.first", first_o,  (b == 0));
            checkOutput("bit.ack",   ack_o,    0);
            checkOutput("bit.empty", empty_o,  (b == DATA_W-1));
        end
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        #1;
        checkIdle("rst");
        checkOutput("rst.src", src_o, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus('0, '0);
        #12;
        checkIdle("por");
        checkOutput("por.src", src_o, 0);
        reset = 1'b0;

        tick();
        checkIdle("idle_noreq");

        $display("[TB] single request");
        applyStimulus(4'b0100, 16'h0B00);
        runWord(2, 4'b1011, 4'b0000, 16'h0B00);
        tick();
        checkIdle("single.after");
        checkOutput("single.src_hold", src_o, 2);

        doReset();

        $display("[TB] contention");
        applyStimulus(4'b1111, 16'h8421);
        runWord(0, 4'h1, 4'b1111, 16'h8421);
        runWord(1, 4'h2, 4'b1111, 16'h8421);
        runWord(2, 4'h4, 4'b1111, 16'h8421);
        runWord(3, 4'h8, 4'b1111, 16'h8421);
        runWord(0, 4'h1, 4'b1111, 16'h8421);

        $display("[TB] fairness");
        applyStimulus(4'b1001, 16'h8421);
        runWord(3, 4'h8, 4'b1001, 16'h8421);
        runWord(0, 4'h1, 4'b1001, 16'h8421);
        runWord(3, 4'h8, 4'b1001, 16'h8421);
        runWord(0, 4'h1, 4'b0000, 16'h8421);
        tick();
        checkIdle("fair.after");

        $display("[TB] late data change");
        applyStimulus(4'b0010, 16'h0060);
        runWord(1, 4'b0110, 4'b0000, 16'h0090);
        tick();
        checkIdle("late.after");

        $display("[TB] withdrawn request");
        applyStimulus(4'b0001, 16'h000A);
        runWord(0, 4'b1010, 4'b0010, 16'h000A);
        applyStimulus(4'b0000, 16'h000A);
        tick();
        checkIdle("wd.gap");
        tick();
        checkIdle("wd.after");
        checkOutput("wd.src", src_o, 0);

        $display("[TB] reset mid-word");
        applyStimulus(4'b0100, 16'h0F00);
        tick();
        checkOutput("mid.ack", ack_o, 4'b0100);
        applyStimulus(4'b0000, 16'h0F00);
        tick();
        checkOutput("mid.b0", valid_o, 1);
        tick();
        checkOutput("mid.b1", valid_o, 1);
        #2 reset = 1'b1;
        #1;
        checkIdle("mid.rst");
        checkOutput("mid.rst_src", src_o, 0);
        tick();
        checkIdle("mid.hold");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b1110, 16'h0050);
        runWord(1, 4'b0101, 4'b0000, 16'h0050);
        tick();
        checkIdle("mid.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
